code_calculator: RTL and testbench

- Pipelined 4-operand code calculator.
- Accepts four 4-bit codes and a 4-bit option word, interprets the codes as signed or unsigned, and sorts them ascending or descending.
- Applies one of four arithmetic formulas and returns a 9-bit two's-complement result.
- Sits as a leaf compute block between a stimulus/control source and a result consumer; the verification counterpart is the PATTERN bench.

---
 rtl/cc_pkg.sv | 28 ++
 rtl/cc_sort4.sv | 57 +++++
 rtl/code_calculator.sv | 98 +++++++++
 tb/tb_code_calculator.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/cc_pkg.sv
// rtl/cc_pkg.sv - shared types, widths and compare helper for code_calculator
package cc_pkg;

    localparam int OPW  = 4;
    localparam int RESW = 9;

    typedef enum logic [1:0] {
        OP_SUM    = 2'b00,
        OP_MULSUB = 2'b01,
        OP_ALT    = 2'b10,
        OP_CROSS  = 2'b11
    } op_e;

    // Packed MSB-first so the struct overlays opt[3:0] directly.
    typedef struct packed {
        op_e  op;
        logic descending;
        logic signed_mode;
    } opt_t;

    // True when the pair (a, b) must be swapped to satisfy the requested order.
    function automatic logic out_of_order(input logic signed [RESW-1:0] a,
                                          input logic signed [RESW-1:0] b,
                                          input logic descending);
        return descending ? (a < b) : (a > b);
    endfunction

endpackage

// File: rtl/cc_sort4.sv
// rtl/cc_sort4.sv - combinational 5-comparator sorting network, 4 signed values
module cc_sort4
    import cc_pkg::*;
(
    input  logic                   descending,
    input  logic signed [RESW-1:0] a0,
    input  logic signed [RESW-1:0] a1,
    input  logic signed [RESW-1:0] a2,
    input  logic signed [RESW-1:0] a3,
    output logic signed [RESW-1:0] s0,
    output logic signed [RESW-1:0] s1,
    output logic signed [RESW-1:0] s2,
    output logic signed [RESW-1:0] s3
);

    logic signed [RESW-1:0] l1_0, l1_1, l1_2, l1_3;
    logic signed [RESW-1:0] l2_0, l2_1, l2_2, l2_3;

    // Layers: (0,1)(2,3) -> (0,2)(1,3) -> (1,2)
    always_comb begin
        l1_0 = a0;
        l1_1 = a1;
        l1_2 = a2;
        l1_3 = a3;
        if (out_of_order(a0, a1, descending)) begin
            l1_0 = a1;
            l1_1 = a0;
        end
        if (out_of_order(a2, a3, descending)) begin
            l1_2 = a3;
            l1_3 = a2;
        end

        l2_0 = l1_0;
        l2_1 = l1_1;
        l2_2 = l1_2;
        l2_3 = l1_3;
        if (out_of_order(l1_0, l1_2, descending)) begin
            l2_0 = l1_2;
            l2_2 = l1_0;
        end
        if (out_of_order(l1_1, l1_3, descending)) begin
            l2_1 = l1_3;
            l2_3 = l1_1;
        end

        s0 = l2_0;
        s1 = l2_1;
        s2 = l2_2;
        s3 = l2_3;
        if (out_of_order(l2_1, l2_2, descending)) begin
            s1 = l2_2;
            s2 = l2_1;
        end
    end

endmodule

// File: rtl/code_calculator.sv
// rtl/code_calculator.sv - two-stage pipelined 4-operand sort-and-compute block
module code_calculator
    import cc_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [OPW-1:0]  in_n0,
    input  logic [OPW-1:0]  in_n1,
    input  logic [OPW-1:0]  in_n2,
    input  logic [OPW-1:0]  in_n3,
    input  logic [OPW-1:0]  opt,
    output logic            out_valid,
    output logic [RESW-1:0] out_n
);

    logic           s1_valid;
    logic [OPW-1:0] s1_n0, s1_n1, s1_n2, s1_n3;
    opt_t           s1_opt;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_n0    <= '0;
            s1_n1    <= '0;
            s1_n2    <= '0;
            s1_n3    <= '0;
            s1_opt   <= '0;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_n0  <= in_n0;
                s1_n1  <= in_n1;
                s1_n2  <= in_n2;
                s1_n3  <= in_n3;
                s1_opt <= opt_t'(opt);
            end
        end
    end

    function automatic logic signed [RESW-1:0] extend(input logic [OPW-1:0] code,
                                                      input logic is_signed);
        logic fill;
        fill = is_signed & code[OPW-1];
        return {{(RESW-OPW){fill}}, code};
    endfunction

    logic signed [RESW-1:0] e0, e1, e2, e3;
    logic signed [RESW-1:0] s0, s1, s2, s3;

    assign e0 = extend(s1_n0, s1_opt.signed_mode);
    assign e1 = extend(s1_n1, s1_opt.signed_mode);
    assign e2 = extend(s1_n2, s1_opt.signed_mode);
    assign e3 = extend(s1_n3, s1_opt.signed_mode);

    cc_sort4 u_sort (
        .descending (s1_opt.descending),
        .a0         (e0),
        .a1         (e1),
        .a2         (e2),
        .a3         (e3),
        .s0         (s0),
        .s1         (s1),
        .s2         (s2),
        .s3         (s3)
    );

    // 12-bit working width holds every intermediate; the 9 LSBs are the result.
    logic signed [11:0] w0, w1, w2, w3;
    logic signed [11:0] result;

    assign w0 = 12'(s0);
    assign w1 = 12'(s1);
    assign w2 = 12'(s2);
    assign w3 = 12'(s3);

    always_comb begin
        result = '0;
        case (s1_opt.op)
            OP_SUM:    result = w0 + w1 + w2 + w3;
            OP_MULSUB: result = (w0 * w1) - w2;
            OP_ALT:    result = w0 - w1 + w2 - w3;
            OP_CROSS:  result = (w3 * w2) - (w1 * w0);
            default:   result = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_n     <= '0;
        end else begin
            out_valid <= s1_valid;
            out_n     <= s1_valid ? result[RESW-1:0] : '0;
        end
    end

endmodule

// File: tb/tb_code_calculator.sv
// tb/tb_code_calculator.sv - directed self-checking bench for code_calculator
module tb_code_calculator;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [3:0] in_n0, in_n1, in_n2, in_n3, opt;
    logic       out_valid;
    logic [8:0] out_n;

    int checks = 0;
    int errors = 0;

    code_calculator dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_n0     (in_n0),
        .in_n1     (in_n1),
        .in_n2     (in_n2),
        .in_n3     (in_n3),
        .opt       (opt),
        .out_valid (out_valid),
        .out_n     (out_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%03h expected 0x%03h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                         input logic [3:0] d, input logic [3:0] o);
        in_valid = 1'b1;
        in_n0 = a;
        in_n1 = b;
        in_n2 = c;
        in_n3 = d;
        in_i_opt_set(o);
    endtask

    task automatic in_i_opt_set(input logic [3:0] o);
        opt = o;
    endtask

    // Single vector: drive before edge k, expect the strobe after edge k+1, gone after k+2.
    task automatic single(input string tag, input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] c, input logic [3:0] d, input logic [3:0] o,
                          input logic [8:0] exp);
        @(negedge clk);
        drive(a, b, c, d, o);
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, "_early_valid"}, {8'd0, out_valid}, 9'd0);
        @(posedge clk);
        #1;
        check({tag, "_valid"}, {8'd0, out_valid}, 9'd1);
        check({tag, "_n"}, out_n, exp);
        @(posedge clk);
        #1;
        check({tag, "_valid_drop"}, {8'd0, out_valid}, 9'd0);
        check({tag, "_n_zero"}, out_n, 9'd0);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_n0 = '0; in_n1 = '0; in_n2 = '0; in_n3 = '0; opt = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", {8'd0, out_valid}, 9'd0);
        check("reset_n", out_n, 9'd0);
        @(negedge clk);
        rst = 1'b0;

        single("usum",      4'd3, 4'd9, 4'd1, 4'd12, 4'b0000, 9'h019);
        single("smulsub",   4'hF, 4'h8, 4'h2, 4'h7,  4'b0101, 9'h006);
        single("ucross_d",  4'd15, 4'd15, 4'd0, 4'd0, 4'b1110, 9'h11F);
        single("salt_a",    4'h7, 4'h8, 4'h0, 4'hF,  4'b1001, 9'h1F2);
        single("umulsub_d", 4'd2, 4'd5, 4'd3, 4'd1,  4'b0110, 9'h00D);
        single("scross_d",  4'h8, 4'h8, 4'h7, 4'h7,  4'b1111, 9'h00F);
        single("ssum_min",  4'h8, 4'h8, 4'h8, 4'h8,  4'b0001, 9'h1E0);

        // Back-to-back acceptance on consecutive edges.
        @(negedge clk);
        drive(4'd3, 4'd9, 4'd1, 4'd12, 4'b0000);
        @(negedge clk);
        drive(4'hF, 4'h8, 4'h2, 4'h7, 4'b0101);
        @(negedge clk);
        in_valid = 1'b0;
        check("b2b_v1_valid", {8'd0, out_valid}, 9'd1);
        check("b2b_v1_n", out_n, 9'h019);
        @(posedge clk);
        #1;
        check("b2b_v2_valid", {8'd0, out_valid}, 9'd1);
        check("b2b_v2_n", out_n, 9'h006);
        @(posedge clk);
        #1;
        check("b2b_end_valid", {8'd0, out_valid}, 9'd0);
        check("b2b_end_n", out_n, 9'd0);

        // Reset on the edge after acceptance drops the in-flight sample.
        @(negedge clk);
        drive(4'd3, 4'd9, 4'd1, 4'd12, 4'b0000);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstmid_k1_valid", {8'd0, out_valid}, 9'd0);
        check("rstmid_k1_n", out_n, 9'd0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("rstmid_k%0d_valid", i + 2), {8'd0, out_valid}, 9'd0);
            check($sformatf("rstmid_k%0d_n", i + 2), out_n, 9'd0);
        end
        single("after_rst", 4'h7, 4'h8, 4'h0, 4'hF, 4'b1001, 9'h1F2);

        // Input on the same edge as reset is discarded.
        @(negedge clk);
        drive(4'd15, 4'd15, 4'd0, 4'd0, 4'b1110);
        rst = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("rst_same_valid_%0d", i), {8'd0, out_valid}, 9'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
